// File: rtl/lane_ram.sv
// rtl/lane_ram.sv - lane-masked single-clock RAM with pipelined reads and zero-fill engine
module lane_ram #(
  parameter int LANE_WIDTH     = 8,
  parameter int NUM_LANES      = 4,
  parameter int ADDR_WIDTH     = 12,
  parameter int OUTPUT_REG     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             read_req,
  input  logic [ADDR_WIDTH-1:0]            read_addr,
  output logic [LANE_WIDTH*NUM_LANES-1:0]  read_data,
  output logic                             read_valid,
  input  logic                             write_req,
  input  logic [ADDR_WIDTH-1:0]            write_addr,
  input  logic [LANE_WIDTH*NUM_LANES-1:0]  write_data,
  input  logic [NUM_LANES-1:0]             write_mask,
  input  logic                             clear_req,
  output logic                             busy
);

  localparam int W     = LANE_WIDTH * NUM_LANES;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  localparam logic [0:0] RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  logic [W-1:0]          mem [DEPTH];
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  rd_accept;
  logic                  wr_accept;
  logic [W-1:0]          wr_bits;
  logic [W-1:0]          rd_word;
  logic                  valid1;
  logic [W-1:0]          data1;

  assign busy      = (state == CLEAR);
  assign rd_accept = read_req  && !busy;
  assign wr_accept = write_req && !busy;

  // Expand the lane mask to a bit mask and merge a colliding write into the read word (write-first per lane)
  always_comb begin
    wr_bits = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      wr_bits[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{write_mask[i]}};
    end
    rd_word = mem[read_addr];
    if (wr_accept && (write_addr == read_addr)) begin
      rd_word = (rd_word & ~wr_bits) | (write_data & wr_bits);
    end
  end

  // Memory array: zero-fill has priority, otherwise a lane-masked user write; never touched by reset
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_accept) begin
      mem[write_addr] <= (mem[write_addr] & ~wr_bits) | (write_data & wr_bits);
    end
  end

  // Zero-fill FSM: sweeps clr_cnt across the whole array once, ignoring clear_req while sweeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) state <= CLEAR;
        end
        default: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == {ADDR_WIDTH{1'b1}}) state <= IDLE;
        end
      endcase
    end
  end

  // First read stage: capture the word for each accepted read; data holds between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid1 <= 1'b0;
      data1  <= '0;
    end else begin
      valid1 <= rd_accept;
      if (rd_accept) data1 <= rd_word;
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      logic         valid2;
      logic [W-1:0] data2;

      // Optional output stage: retime the first stage, holding data while no read completes
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid2 <= 1'b0;
          data2  <= '0;
        end else begin
          valid2 <= valid1;
          if (valid1) data2 <= data1;
        end
      end

      assign read_valid = valid2;
      assign read_data  = data2;
    end else begin : g_no_out_reg
      assign read_valid = valid1;
      assign read_data  = data1;
    end
  endgenerate

endmodule

// File: doc/lane_ram.md
LANE_RAM -- requirements
Module: lane_ram

Interface
REQ-001 SHALL have parameter LANE_WIDTH, default 8, giving the bits per write lane.
REQ-002 SHALL have parameter NUM_LANES, default 4, giving the lanes per word; word width W = LANE_WIDTH*NUM_LANES.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, giving a depth of 2^ADDR_WIDTH words.
REQ-004 SHALL have parameter OUTPUT_REG, default 1, where 1 adds an output register stage.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, where 1 zero-fills the memory after reset release.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-008 SHALL have port read_req, input, 1 bit: read strobe, one word per cycle.
REQ-009 SHALL have port read_addr, input, ADDR_WIDTH bits: the read address.
REQ-010 SHALL have port read_data, output, W bits: the read word.
REQ-011 SHALL have port read_valid, output, 1 bit: qualifies read_data for exactly one cycle.
REQ-012 SHALL have port write_req, input, 1 bit: write strobe.
REQ-013 SHALL have port write_addr, input, ADDR_WIDTH bits: the write address.
REQ-014 SHALL have port write_data, input, W bits: the write word.
REQ-015 SHALL have port write_mask, input, NUM_LANES bits: bit i enables lane i, i.e. bits [i*LANE_WIDTH +: LANE_WIDTH].
REQ-016 SHALL have port clear_req, input, 1 bit: a one-cycle pulse that starts a zero-fill.
REQ-017 SHALL have port busy, output, 1 bit: high while a zero-fill is in progress.

Function
REQ-018 SHALL contain a 2-state FSM: IDLE and CLEAR; busy = (state==CLEAR).
REQ-019 IDLE -> CLEAR SHALL occur on the clock edge sampling clear_req=1; busy rises the following cycle.
REQ-020 In CLEAR, the block SHALL write all-zero, all lanes, to address clr_cnt each cycle, with clr_cnt counting 0 to 2^ADDR_WIDTH-1.
REQ-021 CLEAR -> IDLE SHALL occur after the write to address 2^ADDR_WIDTH-1; clr_cnt returns to 0; CLEAR lasts exactly 2^ADDR_WIDTH cycles.
REQ-022 clear_req SHALL be ignored while in CLEAR (no restart, no extension).
REQ-023 While busy=1, read_req and write_req SHALL be ignored: no memory write and no read_valid generated.
REQ-024 A read accepted (read_req=1, busy=0) in cycle N SHALL produce read_valid=1 and read_data in cycle N+1+OUTPUT_REG.
REQ-025 A read accepted in the cycle before busy rises SHALL complete normally.
REQ-026 Reads SHALL be fully pipelined; back-to-back reads SHALL give back-to-back read_valid pulses in issue order.
REQ-027 read_data SHALL hold its last value whenever read_valid=0.
REQ-028 A write accepted (write_req=1, busy=0) SHALL update only the lanes whose write_mask bit is 1; other lanes keep their old contents.
REQ-029 A write with write_mask=0 SHALL leave memory unchanged.
REQ-030 Same-cycle read and write to the same address SHALL be write-first per lane: masked lanes return write_data, unmasked lanes return the prior contents.
REQ-031 Same-cycle read and write to different addresses SHALL both complete independently.
REQ-032 A read of an address written in the previous cycle SHALL return the new data.
REQ-033 Address arithmetic SHALL be unsigned ADDR_WIDTH-bit; clr_cnt wraps only at the CLEAR exit.

Reset
REQ-034 While reset=0: read_data=0, read_valid=0, all pipeline valid bits=0, clr_cnt=0.
REQ-035 While reset=0: state=CLEAR if CLEAR_ON_RESET=1 (busy=1), else IDLE (busy=0).
REQ-036 Reset SHALL NOT directly modify memory contents; zero-fill happens only via CLEAR after release.
REQ-037 Reset asserted mid-CLEAR SHALL abort the fill; after release the fill restarts at address 0 if CLEAR_ON_RESET=1, else memory is left partially cleared.
REQ-038 Read data in flight at reset assertion SHALL be discarded (no read_valid).

Verification (ADDR_WIDTH=4, LANE_WIDTH=8, NUM_LANES=4, OUTPUT_REG=1, CLEAR_ON_RESET=1)
REQ-039 Release reset -> busy=1 for exactly 16 cycles; then reading addresses 0-15 returns 32'h0 with read_valid 2 cycles after each read_req.
REQ-040 Write addr 5 = 32'hAABBCCDD with mask 4'b1111, then write addr 5 = 32'h11223344 with mask 4'b0101, then read addr 5 -> 32'hAA22CC44.
REQ-041 Same cycle: write addr 3 = 32'hFFFFFFFF with mask 4'b0011, and read addr 3 with prior content 32'h12345678 -> read_data = 32'h1234FFFF two cycles later.
REQ-042 Pulse clear_req while 4 reads are in flight -> all 4 read_valid pulses are delivered; read_req and write_req during the 16 busy cycles are ignored; all addresses read 0 afterwards.
REQ-043 Assert reset at clr_cnt=7, release 2 cycles later -> busy=1 for 16 more cycles and read_valid=0 throughout.
REQ-044 Repeat REQ-040 with OUTPUT_REG=0 -> same data, with read latency 1 cycle.
